// File: rtl/conv2x2_frame_ctrl.sv
// Frame sequencer for Con2x2: buffers a frame, then clears, loads and streams the engine gaplessly.
// Results are tagged with window (row,col) via a RES_LAT-deep tag pipe; pixel input stalls only outside FILL.
module conv2x2_frame_ctrl #(
  parameter int dataSize   = 8,
  parameter int IMG_WIDTH  = 4,
  parameter int IMG_HEIGHT = 4,
  parameter int RES_LAT    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [dataSize-1:0]           w1,
  input  logic [dataSize-1:0]           w2,
  input  logic [dataSize-1:0]           w3,
  input  logic [dataSize-1:0]           w4,
  input  logic [dataSize-1:0]           s_pixel_data,
  input  logic                          s_pixel_valid,
  output logic                          s_pixel_ready,
  output logic                          conv_rst,
  output logic                          conv_kernel_load_valid,
  output logic [dataSize-1:0]           conv_w1,
  output logic [dataSize-1:0]           conv_w2,
  output logic [dataSize-1:0]           conv_w3,
  output logic [dataSize-1:0]           conv_w4,
  output logic [dataSize-1:0]           conv_pixel_in,
  input  logic [2*dataSize+4:0]         conv_result,
  output logic [2*dataSize+4:0]         result,
  output logic                          result_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0] result_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  result_col,
  output logic                          busy,
  output logic                          done
);

  localparam int N   = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW  = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2(N + RES_LAT + 1);
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam int CLW = $clog2(IMG_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_CLEAR, S_LOAD, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [dataSize-1:0] r_ram [N];
  logic [dataSize-1:0] r_w1, r_w2, r_w3, r_w4;
  logic [CW-1:0]       r_cnt;
  logic [RW-1:0]       r_row;
  logic [CLW-1:0]      r_col;
  logic                r_in_rst;

  logic                r_tag_vld [RES_LAT];
  logic [RW-1:0]       r_tag_row [RES_LAT];
  logic [CLW-1:0]      r_tag_col [RES_LAT];

  logic w_accept;
  logic w_last_px;
  logic w_last_drain;
  logic w_legal;

  assign w_accept     = (r_state == S_FILL) && s_pixel_valid;
  assign w_last_px    = (r_cnt == CW'(N - 1));
  assign w_last_drain = (r_cnt == CW'(RES_LAT - 1));
  // Row 0 windows lack an upper line; column 0 windows straddle two rows.
  assign w_legal      = (r_state == S_STREAM) && (r_row != '0) && (r_col != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_FILL;
      S_FILL:   if (w_accept && w_last_px) w_state_nxt = S_CLEAR;
      S_CLEAR:  w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_STREAM;
      S_STREAM: if (w_last_px) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_last_drain) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_in_rst <= 1'b1;
      r_w1     <= '0;
      r_w2     <= '0;
      r_w3     <= '0;
      r_w4     <= '0;
      r_cnt    <= '0;
      r_row    <= '0;
      r_col    <= '0;
    end else begin
      r_in_rst <= 1'b0;
      if ((r_state == S_IDLE) && start) begin
        r_w1 <= w1;
        r_w2 <= w2;
        r_w3 <= w3;
        r_w4 <= w4;
      end
      // One counter serves as write index, stream index and drain timer.
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (w_accept || (r_state == S_STREAM) || (r_state == S_DRAIN)) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state != S_STREAM) begin
        r_row <= '0;
        r_col <= '0;
      end else if (r_col == CLW'(IMG_WIDTH - 1)) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CLW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ram[r_cnt[AW-1:0]] <= s_pixel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RES_LAT; i++) begin
        r_tag_vld[i] <= 1'b0;
        r_tag_row[i] <= '0;
        r_tag_col[i] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_legal;
      r_tag_row[0] <= r_row;
      r_tag_col[0] <= r_col;
      for (int i = 1; i < RES_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_row[i] <= r_tag_row[i-1];
        r_tag_col[i] <= r_tag_col[i-1];
      end
    end
  end

  always_comb begin
    s_pixel_ready          = (r_state == S_FILL);
    conv_rst               = r_in_rst || (r_state == S_CLEAR);
    conv_kernel_load_valid = (r_state == S_LOAD);
    conv_pixel_in          = (r_state == S_STREAM) ? r_ram[r_cnt[AW-1:0]] : '0;
    busy                   = (r_state != S_IDLE);
    done                   = (r_state == S_DONE);
    result_valid           = r_tag_vld[RES_LAT-1];
    result                 = r_tag_vld[RES_LAT-1] ? conv_result : '0;
    result_row             = r_tag_vld[RES_LAT-1] ? r_tag_row[RES_LAT-1] : '0;
    result_col             = r_tag_vld[RES_LAT-1] ? r_tag_col[RES_LAT-1] : '0;
  end

  assign conv_w1 = r_w1;
  assign conv_w2 = r_w2;
  assign conv_w3 = r_w3;
  assign conv_w4 = r_w4;

endmodule

// File: tb/tb_conv2x2_frame_ctrl.sv
// Directed bench for conv2x2_frame_ctrl at default parameters (4x4 frame, RES_LAT=4).
module tb_conv2x2_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  w1, w2, w3, w4;
  logic [7:0]  s_pixel_data;
  logic        s_pixel_valid;
  logic        s_pixel_ready;
  logic        conv_rst;
  logic        conv_kernel_load_valid;
  logic [7:0]  conv_w1, conv_w2, conv_w3, conv_w4;
  logic [7:0]  conv_pixel_in;
  logic [20:0] cyc = '0;
  logic [20:0] result;
  logic        result_valid;
  logic [1:0]  result_row;
  logic [1:0]  result_col;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  conv2x2_frame_ctrl dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .w1                     (w1),
    .w2                     (w2),
    .w3                     (w3),
    .w4                     (w4),
    .s_pixel_data           (s_pixel_data),
    .s_pixel_valid          (s_pixel_valid),
    .s_pixel_ready          (s_pixel_ready),
    .conv_rst               (conv_rst),
    .conv_kernel_load_valid (conv_kernel_load_valid),
    .conv_w1                (conv_w1),
    .conv_w2                (conv_w2),
    .conv_w3                (conv_w3),
    .conv_w4                (conv_w4),
    .conv_pixel_in          (conv_pixel_in),
    .conv_result            (cyc),
    .result                 (result),
    .result_valid           (result_valid),
    .result_row             (result_row),
    .result_col             (result_col),
    .busy                   (busy),
    .done                   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 21'd1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle c counts from the N-th accepted pixel (c=1 is CLEAR).
  task automatic run_frame(input logic [7:0] wa, input logic [7:0] wb, input logic [7:0] wc,
                           input logic [7:0] wd, input logic [7:0] base, input bit bubbles,
                           input int abort_c, input bit fill_start);
    int          acc;
    int          guard;
    int          nvalid;
    int          k;
    bit          legal;
    logic [20:0] pcyc [16];
    logic [31:0] exp_pix;
    start = 1'b1; w1 = wa; w2 = wb; w3 = wc; w4 = wd; s_pixel_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    chk("ready_fill", 32'(s_pixel_ready), 32'd1);
    acc = 0;
    guard = 0;
    while (acc < 16 && guard < 400) begin
      s_pixel_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      s_pixel_data  = base + 8'(acc);
      start = fill_start && (acc == 5);
      if (fill_start && acc == 5) begin
        w1 = 8'hEE; w2 = 8'hEE; w3 = 8'hEE; w4 = 8'hEE;
      end
      if (s_pixel_valid && s_pixel_ready) acc++;
      guard++;
      tick();
    end
    chk("fill_count", 32'(acc), 32'd16);
    s_pixel_valid = 1'b0;
    start = 1'b0;
    nvalid = 0;
    for (int c = 1; c <= 24; c++) begin
      k = c - 7;
      legal = (k >= 0) && (k < 16) && (k / 4 >= 1) && (k % 4 >= 1);
      exp_pix = (c >= 3 && c <= 18) ? 32'(base) + 32'(c - 3) : 32'd0;
      chk("conv_rst", 32'(conv_rst), 32'(c == 1));
      chk("load_valid", 32'(conv_kernel_load_valid), 32'(c == 2));
      chk("pixel_in", 32'(conv_pixel_in), exp_pix);
      chk("done", 32'(done), 32'(c == 23));
      chk("busy", 32'(busy), 32'(c <= 23));
      chk("ready_low", 32'(s_pixel_ready), 32'd0);
      chk("result_valid", 32'(result_valid), 32'(legal));
      if (c == 2) begin
        chk("w1", 32'(conv_w1), 32'(wa));
        chk("w2", 32'(conv_w2), 32'(wb));
        chk("w3", 32'(conv_w3), 32'(wc));
        chk("w4", 32'(conv_w4), 32'(wd));
      end
      if (c >= 3 && c <= 18) pcyc[c-3] = cyc;
      if (legal) begin
        chk("result_row", 32'(result_row), 32'(k / 4));
        chk("result_col", 32'(result_col), 32'(k % 4));
        chk("result", 32'(result), 32'(pcyc[k] + 21'd4));
      end
      nvalid += int'(result_valid);
      if (c == abort_c) begin
        rst = 1'b0;
        tick();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_conv_rst", 32'(conv_rst), 32'd1);
        chk("abort_rv", 32'(result_valid), 32'd0);
        rst = 1'b1;
        for (int j = 0; j < 8; j++) begin
          tick();
          chk("post_abort_rv", 32'(result_valid), 32'd0);
          chk("post_abort_done", 32'(done), 32'd0);
          chk("post_abort_busy", 32'(busy), 32'd0);
        end
        return;
      end
      tick();
    end
    chk("valid_count", 32'(nvalid), 32'd9);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; s_pixel_valid = 1'b0; s_pixel_data = '0;
    w1 = 8'h11; w2 = 8'h22; w3 = 8'h33; w4 = 8'h44;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_conv_rst", 32'(conv_rst), 32'd1);
      chk("rst_ready", 32'(s_pixel_ready), 32'd0);
      chk("rst_load", 32'(conv_kernel_load_valid), 32'd0);
      chk("rst_rv", 32'(result_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_w1", 32'(conv_w1), 32'd0);
      chk("rst_pix", 32'(conv_pixel_in), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_row", 32'(result_row), 32'd0);
      chk("rst_col", 32'(result_col), 32'd0);
    end
    rst = 1'b1;
    s_pixel_valid = 1'b1;
    s_pixel_data = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_conv_rst", 32'(conv_rst), 32'd0);
      chk("idle_ready", 32'(s_pixel_ready), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    run_frame(8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 1'b0, 0, 1'b0);
    run_frame(8'd5, 8'd6, 8'd7, 8'd8, 8'h40, 1'b1, 0, 1'b0);
    run_frame(8'd9, 8'd10, 8'd11, 8'd12, 8'h80, 1'b0, 10, 1'b0);
    run_frame(8'd1, 8'd1, 8'd2, 8'd2, 8'h20, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_frame_busy", 32'(busy), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100us");
    $fatal(1, "watchdog expired");
  end

endmodule
